fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stage_sync_fifo.sv | 62 ++++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// default geometry and the counter-width helper.
package fetch_pkg;

    localparam int DEF_PCW   = 32;
    localparam int DEF_IW    = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Counters must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Small synchronous FIFO with a combinational head view, so an entry
// written on one edge is readable right after it. Supports push and pop
// in the same cycle even when full, plus a synchronous clear.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          push,
    input  logic [W-1:0]                  push_data,
    input  logic                          pop,
    output logic [W-1:0]                  head,
    output logic [cnt_width(DEPTH)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop & ~w_empty & ~clr;
    // A full FIFO may still accept a push when the head leaves this cycle.
    assign w_do_push = push & (~w_full | w_do_pop) & ~clr;

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues requests at the current PC while credit
// allows, tracks in-flight requests in a pending-PC FIFO, and queues
// responses with their PC for decode. A branch flushes the queue and
// discards every response still in flight.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int PCW   = DEF_PCW,
    parameter int IW    = DEF_IW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [PCW-1:0] pc_in,
    input  logic           branch,
    input  logic           halt,
    output logic           pc_stall,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [IW-1:0]  imem_rdata,
    output logic           if_valid,
    input  logic           if_ready,
    output logic [IW-1:0]  if_instr,
    output logic [PCW-1:0] if_pc
);
    localparam int CW = cnt_width(DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [CW-1:0]      r_discard_cnt;
    logic [CW-1:0]      w_outstanding;
    logic [CW-1:0]      w_q_count;
    logic [CW-1:0]      w_discard_at_branch;
    logic [CW:0]        w_in_use;
    logic               w_credit_ok;
    logic               w_rsp;
    logic               w_accept;
    logic               w_q_push;
    logic               w_q_pop;
    logic [PCW-1:0]     w_rsp_pc;
    logic [PCW+IW-1:0]  w_q_head;

    // A response with nothing outstanding belongs to a pre-reset request.
    assign w_rsp       = imem_rvalid & (w_outstanding != '0);
    assign w_in_use    = {1'b0, w_q_count} + {1'b0, w_outstanding};
    assign w_credit_ok = (w_in_use < (CW+1)'(DEPTH));
    assign w_accept    = imem_req & imem_gnt;
    assign pc_stall    = ~w_accept;
    assign imem_addr   = pc_in;

    // Everything still in flight after this cycle's response is stale.
    assign w_discard_at_branch = w_outstanding - CW'(w_rsp);

    assign w_q_push = w_rsp & ~branch & (r_discard_cnt == '0);
    assign w_q_pop  = if_valid & if_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // Next-state and request generation; branch overrides every other event.
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        if (branch) begin
            w_state_next = (w_discard_at_branch != '0) ? FLUSH : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt) w_state_next = HALTED;
                    else      imem_req     = w_credit_ok & ~rst;
                end
                FLUSH:   if (r_discard_cnt == '0) w_state_next = RUN;
                HALTED:  if (!halt)               w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    // Count of stale responses still to be dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_discard_cnt <= '0;
        else if (branch)                           r_discard_cnt <= w_discard_at_branch;
        else if (w_rsp && r_discard_cnt != '0)     r_discard_cnt <= r_discard_cnt - CW'(1);
    end

    // PCs of accepted requests, in issue order; its occupancy is the outstanding count.
    sync_fifo #(
        .W     (PCW),
        .DEPTH (DEPTH)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (w_accept),
        .push_data (pc_in),
        .pop       (w_rsp),
        .head      (w_rsp_pc),
        .count     (w_outstanding)
    );

    // Fetched {pc, instruction} pairs waiting for decode.
    sync_fifo #(
        .W     (PCW + IW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (branch),
        .push      (w_q_push),
        .push_data ({w_rsp_pc, imem_rdata}),
        .pop       (w_q_pop),
        .head      (w_q_head),
        .count     (w_q_count)
    );

    assign if_valid = (w_q_count != '0);
    assign if_pc    = w_q_head[PCW+IW-1:IW];
    assign if_instr = w_q_head[IW-1:0];

endmodule
